control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 5: width of the instruction opcode field.
REQ-002 Parameter OPSEL_W, default 5: width of the ALU operation select.
REQ-003 Parameter ADD_SEL, default 5'b00011: op_sel value for address addition.
REQ-004 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_rdy.
REQ-005 clk  in  1  single system clock; all state changes on rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 run  in  1  level; permits fetch to start from IDLE.
REQ-008 mem_rdy  in  1  memory completes the current Read/Write this cycle.
REQ-009 ir_op  in  OPW  opcode field of IR, valid from T3 onward.
REQ-010 ctrl  out  19  strobe bundle: PC_out, MAR_rd, IncPC, Zlo_rd, Zlo_out, PC_rd, Read, Write, MDR_rd, MDR_out, IR_rd, Gra, Grb, Grc, BAout, R_out, Rin, Y_rd, C_out.
REQ-011 op_sel  out  OPSEL_W  ALU operation select; 0 when unused.
REQ-012 step  out  4  current state encoding, for debug.
REQ-013 illegal  out  1  one-cycle pulse on an undefined opcode.
REQ-014 mem_err  out  1  sticky; set on memory timeout.
REQ-015 halted  out  1  high while in HALT.

Function
REQ-016 States: IDLE, T0..T7, HALT; state register binary-encoded; step = state code (IDLE=0, T0..T7=1..8, HALT=15).
REQ-017 ctrl, op_sel: combinational decode of registered state and ir_op only; no combinational path from mem_rdy or run to ctrl.
REQ-018 IDLE -> T0 when run=1; else hold. After each instruction completes: return to T0 if run=1, else IDLE.
REQ-019 Fetch: T0 = PC_out, MAR_rd, IncPC, Zlo_rd; T1 = Zlo_out, PC_rd, Read, MDR_rd; T2 = MDR_out, IR_rd.
REQ-020 Memory wait: in any state asserting Read or Write, hold state and strobes until mem_rdy=1; PC_rd asserts only on the T1 cycle where mem_rdy=1.
REQ-021 Wait counter: counts hold cycles and clears on state change; when it reaches MEM_TIMEOUT with mem_rdy=0, set mem_err and go to HALT next cycle.
REQ-022 LD (opcode 0): T3 Grb, BAout, R_out, Y_rd; T4 C_out, op_sel=ADD_SEL, Zlo_rd; T5 Zlo_out, MAR_rd; T6 Read, MDR_rd (waits); T7 MDR_out, Gra, Rin.
REQ-023 LDI (opcode 1): T3, T4 as LD; T5 Zlo_out, Gra, Rin; then done.
REQ-024 ST (opcode 2): T3–T5 as LD; T6 Gra, R_out, MDR_rd; T7 Write (waits); then done.
REQ-025 ALU (opcodes 3..12): T3 Grb, R_out, Y_rd; T4 Grc, R_out, op_sel=ir_op, Zlo_rd; T5 Zlo_out, Gra, Rin; then done.
REQ-026 NOP (opcode 13): done after T2. HALT (opcode 14): T2 -> HALT; hold until clr.
REQ-027 Any other opcode: pulse illegal during T3 only, no other strobes asserted, then treat as done.
REQ-028 run deasserted mid-instruction: the current instruction completes; run is sampled only at IDLE and at instruction end.
REQ-029 No more than one of PC_out, Zlo_out, MDR_out, R_out, C_out is asserted in any cycle.

Reset
REQ-030 clr=1 forces state IDLE, wait counter 0, mem_err 0, and all ctrl, op_sel, illegal, halted 0, asynchronously, including mid-instruction and during a memory wait.
REQ-031 The first transition out of IDLE occurs at the first rising edge after clr falls on which run=1.

Structure
REQ-032 Shared package holds the state encoding, opcode constants (LD, LDI, ST, ALU range, NOP, HALT), ctrl bit-index constants, and the default ADD_SEL.
REQ-033 Single module; the wait counter is implemented inline, with no sub-module.

Verification
REQ-034 clr pulse, then run=1, ir_op=0 (LD), mem_rdy=1 -> step sequence 1..8 then 1; Read high in T1 and T6; op_sel=3 in T4.
REQ-035 ALU with ir_op=5 -> T4 shows op_sel=5, Grc, R_out, Zlo_rd; Rin and Gra in T5; next state T0.
REQ-036 ST with mem_rdy held low 3 cycles in T7 -> Write held 4 cycles, state stays 8, then T0.
REQ-037 mem_rdy stuck low in T1 -> mem_err=1 after MEM_TIMEOUT cycles; state HALT (15); halted=1 until clr.
REQ-038 ir_op=31 -> illegal pulses one cycle in T3; no ctrl bits set; next state T0.
REQ-039 clr asserted during T6 wait -> all outputs 0 immediately; step=0; after clr falls with run=0, state stays IDLE.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state codes, opcode map,
// strobe bit positions and the default address-add ALU select.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_NOP, CLS_HALT, CLS_BAD
  } op_class_e;

  localparam int OP_LD        = 0;
  localparam int OP_LDI       = 1;
  localparam int OP_ST        = 2;
  localparam int OP_ALU_FIRST = 3;
  localparam int OP_ALU_LAST  = 12;
  localparam int OP_NOP       = 13;
  localparam int OP_HALT      = 14;

  localparam int CTRL_W    = 19;
  localparam int B_PC_OUT  = 0;
  localparam int B_MAR_RD  = 1;
  localparam int B_INC_PC  = 2;
  localparam int B_ZLO_RD  = 3;
  localparam int B_ZLO_OUT = 4;
  localparam int B_PC_RD   = 5;
  localparam int B_READ    = 6;
  localparam int B_WRITE   = 7;
  localparam int B_MDR_RD  = 8;
  localparam int B_MDR_OUT = 9;
  localparam int B_IR_RD   = 10;
  localparam int B_GRA     = 11;
  localparam int B_GRB     = 12;
  localparam int B_GRC     = 13;
  localparam int B_BA_OUT  = 14;
  localparam int B_R_OUT   = 15;
  localparam int B_RIN     = 16;
  localparam int B_Y_RD    = 17;
  localparam int B_C_OUT   = 18;

  localparam logic [4:0] ADD_SEL_DEFAULT = 5'b00011;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and its datapath/memory environment.
interface control_sequencer_if
  import control_sequencer_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int OPSEL_W = 5
);
  logic               run;
  logic               mem_rdy;
  logic [OPW-1:0]     ir_op;
  logic [CTRL_W-1:0]  ctrl;
  logic [OPSEL_W-1:0] op_sel;
  logic [3:0]         step;
  logic               illegal;
  logic               mem_err;
  logic               halted;

  modport master (
    output run, mem_rdy, ir_op,
    input  ctrl, op_sel, step, illegal, mem_err, halted
  );

  modport slave (
    input  run, mem_rdy, ir_op,
    output ctrl, op_sel, step, illegal, mem_err, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired instruction sequencer: fetch T0..T2, execute T3..T7, memory
// wait with timeout, and a sticky halt state left only through clr.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int                 OPW         = 5,
  parameter int                 OPSEL_W     = 5,
  parameter logic [OPSEL_W-1:0] ADD_SEL     = OPSEL_W'(ADD_SEL_DEFAULT),
  parameter int                 MEM_TIMEOUT = 15
) (
  input logic                clk,
  input logic                clr,
  control_sequencer_if.slave bus
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e                state;
  logic [CW-1:0]         wait_cnt;
  logic                  mem_err_q;
  op_class_e             op_class;
  logic [CTRL_W-1:0]     ctrl_d;
  logic [OPSEL_W-1:0]    op_sel_d;
  logic                  illegal_d;
  logic                  mem_access;
  state_e                done_state;

  always_comb begin
    op_class = CLS_BAD;
    if (bus.ir_op == OPW'(OP_LD))
      op_class = CLS_LD;
    else if (bus.ir_op == OPW'(OP_LDI))
      op_class = CLS_LDI;
    else if (bus.ir_op == OPW'(OP_ST))
      op_class = CLS_ST;
    else if (bus.ir_op >= OPW'(OP_ALU_FIRST) && bus.ir_op <= OPW'(OP_ALU_LAST))
      op_class = CLS_ALU;
    else if (bus.ir_op == OPW'(OP_NOP))
      op_class = CLS_NOP;
    else if (bus.ir_op == OPW'(OP_HALT))
      op_class = CLS_HALT;
  end

  // Strobes come from state and opcode only; PC_rd alone is qualified by
  // mem_rdy so the PC is loaded exactly once at the end of the fetch read.
  always_comb begin
    ctrl_d    = '0;
    op_sel_d  = '0;
    illegal_d = 1'b0;
    case (state)
      S_T0: begin
        ctrl_d[B_PC_OUT] = 1'b1;
        ctrl_d[B_MAR_RD] = 1'b1;
        ctrl_d[B_INC_PC] = 1'b1;
        ctrl_d[B_ZLO_RD] = 1'b1;
      end
      S_T1: begin
        ctrl_d[B_ZLO_OUT] = 1'b1;
        ctrl_d[B_READ]    = 1'b1;
        ctrl_d[B_MDR_RD]  = 1'b1;
        ctrl_d[B_PC_RD]   = bus.mem_rdy;
      end
      S_T2: begin
        ctrl_d[B_MDR_OUT] = 1'b1;
        ctrl_d[B_IR_RD]   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl_d[B_GRB]    = 1'b1;
            ctrl_d[B_BA_OUT] = 1'b1;
            ctrl_d[B_R_OUT]  = 1'b1;
            ctrl_d[B_Y_RD]   = 1'b1;
          end
          CLS_ALU: begin
            ctrl_d[B_GRB]   = 1'b1;
            ctrl_d[B_R_OUT] = 1'b1;
            ctrl_d[B_Y_RD]  = 1'b1;
          end
          CLS_BAD: illegal_d = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl_d[B_C_OUT]  = 1'b1;
            ctrl_d[B_ZLO_RD] = 1'b1;
            op_sel_d         = ADD_SEL;
          end
          CLS_ALU: begin
            ctrl_d[B_GRC]    = 1'b1;
            ctrl_d[B_R_OUT]  = 1'b1;
            ctrl_d[B_ZLO_RD] = 1'b1;
            op_sel_d         = OPSEL_W'(bus.ir_op);
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          CLS_LD, CLS_ST: begin
            ctrl_d[B_ZLO_OUT] = 1'b1;
            ctrl_d[B_MAR_RD]  = 1'b1;
          end
          CLS_LDI, CLS_ALU: begin
            ctrl_d[B_ZLO_OUT] = 1'b1;
            ctrl_d[B_GRA]     = 1'b1;
            ctrl_d[B_RIN]     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          CLS_LD: begin
            ctrl_d[B_READ]   = 1'b1;
            ctrl_d[B_MDR_RD] = 1'b1;
          end
          CLS_ST: begin
            ctrl_d[B_GRA]    = 1'b1;
            ctrl_d[B_R_OUT]  = 1'b1;
            ctrl_d[B_MDR_RD] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          CLS_LD: begin
            ctrl_d[B_MDR_OUT] = 1'b1;
            ctrl_d[B_GRA]     = 1'b1;
            ctrl_d[B_RIN]     = 1'b1;
          end
          CLS_ST: ctrl_d[B_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign mem_access = ctrl_d[B_READ] | ctrl_d[B_WRITE];
  assign done_state = bus.run ? S_T0 : S_IDLE;

  // While a Read/Write is outstanding the state is frozen and the hold
  // cycles are counted; running out of patience parks the machine in HALT.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else if (mem_access && !bus.mem_rdy) begin
      if (wait_cnt == CW'(MEM_TIMEOUT)) begin
        state     <= S_HALT;
        mem_err_q <= 1'b1;
        wait_cnt  <= '0;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE: if (bus.run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2: begin
          if (op_class == CLS_HALT)
            state <= S_HALT;
          else if (op_class == CLS_NOP)
            state <= done_state;
          else
            state <= S_T3;
        end
        S_T3:   state <= (op_class == CLS_BAD) ? done_state : S_T4;
        S_T4:   state <= S_T5;
        S_T5: begin
          if (op_class == CLS_LDI || op_class == CLS_ALU)
            state <= done_state;
          else
            state <= S_T6;
        end
        S_T6:   state <= S_T7;
        S_T7:   state <= done_state;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl    = ctrl_d;
  assign bus.op_sel  = op_sel_d;
  assign bus.illegal = illegal_d;
  assign bus.step    = state;
  assign bus.mem_err = mem_err_q;
  assign bus.halted  = (state == S_HALT);

endmodule
